// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences each instruction over several cycles and drives
// every datapath enable/select, including ALU decode, memory wait handshake and illegal-op flag.
module multicycle_control_unit #(
  parameter int unsigned OP_W       = 6,
  parameter int unsigned ALUCTRL_W  = 3,
  parameter int unsigned ENABLE_BNE = 1,
  parameter int unsigned STATE_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_W-1:0]      Op,
  input  logic [OP_W-1:0]      funct,
  input  logic                 zero,
  input  logic                 memReady,
  output logic                 iorD,
  output logic                 irWrite,
  output logic                 memWrite,
  output logic                 regWrite,
  output logic                 regDst,
  output logic                 memToReg,
  output logic                 aluSrcA,
  output logic [1:0]           aluSrcB,
  output logic [1:0]           pcSrc,
  output logic                 pcEn,
  output logic [ALUCTRL_W-1:0] aluControl,
  output logic [STATE_W-1:0]   state,
  output logic                 instrDone,
  output logic                 illegalOp
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_e;

  localparam bit BneEn = (ENABLE_BNE != 0);

  localparam logic [OP_W-1:0] OpRtype = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OpLw    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OpSw    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OpBeq   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OpBne   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OpAddi  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OpJ     = OP_W'(6'b000010);

  localparam logic [OP_W-1:0] FnAdd = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] FnSub = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] FnAnd = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] FnOr  = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] FnSlt = OP_W'(6'b101010);

  localparam logic [ALUCTRL_W-1:0] AluAdd = ALUCTRL_W'(3'b010);
  localparam logic [ALUCTRL_W-1:0] AluSub = ALUCTRL_W'(3'b110);
  localparam logic [ALUCTRL_W-1:0] AluAnd = ALUCTRL_W'(3'b000);
  localparam logic [ALUCTRL_W-1:0] AluOr  = ALUCTRL_W'(3'b001);
  localparam logic [ALUCTRL_W-1:0] AluSlt = ALUCTRL_W'(3'b111);

  state_e                 state_q, state_d;
  logic                   is_bne_q, is_bne_d;
  logic                   dec_illegal;
  logic [ALUCTRL_W-1:0]   alu_funct;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch;
      is_bne_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_bne_q <= is_bne_d;
    end
  end

  always_comb begin
    alu_funct = AluAdd;
    case (funct)
      FnAdd:   alu_funct = AluAdd;
      FnSub:   alu_funct = AluSub;
      FnAnd:   alu_funct = AluAnd;
      FnOr:    alu_funct = AluOr;
      FnSlt:   alu_funct = AluSlt;
      default: alu_funct = AluAdd;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    is_bne_d    = is_bne_q;
    dec_illegal = 1'b0;
    iorD        = 1'b0;
    irWrite     = 1'b0;
    memWrite    = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    pcSrc       = 2'b00;
    pcEn        = 1'b0;
    aluControl  = AluAdd;
    instrDone   = 1'b0;
    illegalOp   = 1'b0;

    case (state_q)
      StFetch: begin
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcEn    = memReady;
        if (memReady) state_d = StDecode;
      end
      StDecode: begin
        aluSrcB  = 2'b11;
        // IR is stable through the instruction, but latch the branch sense once here anyway
        is_bne_d = (Op == OpBne);
        case (Op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpBne: begin
            if (BneEn) state_d = StBranch;
            else       dec_illegal = 1'b1;
          end
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
          illegalOp = 1'b1;
          instrDone = 1'b1;
          state_d   = StFetch;
        end
      end
      StMemAdr: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = (Op == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        iorD = 1'b1;
        if (memReady) state_d = StMemWb;
      end
      StMemWb: begin
        regWrite  = 1'b1;
        memToReg  = 1'b1;
        instrDone = 1'b1;
        state_d   = StFetch;
      end
      StMemWr: begin
        iorD      = 1'b1;
        memWrite  = 1'b1;
        instrDone = memReady;
        if (memReady) state_d = StFetch;
      end
      StExecute: begin
        aluSrcA    = 1'b1;
        aluControl = alu_funct;
        state_d    = StAluWb;
      end
      StAluWb: begin
        regWrite  = 1'b1;
        regDst    = 1'b1;
        instrDone = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        aluSrcA    = 1'b1;
        aluControl = AluSub;
        pcSrc      = 2'b01;
        pcEn       = is_bne_q ? !zero : zero;
        instrDone  = 1'b1;
        state_d    = StFetch;
      end
      StAddiEx: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pcSrc     = 2'b10;
        pcEn      = 1'b1;
        instrDone = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Reset cycle: no side effects, selects parked at their fetch values
    if (reset) begin
      iorD       = 1'b0;
      irWrite    = 1'b0;
      memWrite   = 1'b0;
      regWrite   = 1'b0;
      regDst     = 1'b0;
      memToReg   = 1'b0;
      aluSrcA    = 1'b0;
      aluSrcB    = 2'b01;
      pcSrc      = 2'b00;
      pcEn       = 1'b0;
      aluControl = AluAdd;
      instrDone  = 1'b0;
      illegalOp  = 1'b0;
    end
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: latency table, instruction-level reference model with
// random memory waits, and hand sequences for reset abort and bne-disabled decode.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, zero, memReady;
  logic [5:0] Op, funct;

  logic       iorD, irWrite, memWrite, regWrite, regDst, memToReg, aluSrcA, pcEn;
  logic [1:0] aluSrcB, pcSrc;
  logic [2:0] aluControl;
  logic [3:0] state;
  logic       instrDone, illegalOp;

  logic       nb_iorD, nb_irWrite, nb_memWrite, nb_regWrite, nb_regDst, nb_memToReg;
  logic       nb_aluSrcA, nb_pcEn, nb_instrDone, nb_illegalOp;
  logic [1:0] nb_aluSrcB, nb_pcSrc;
  logic [2:0] nb_aluControl;
  logic [3:0] nb_state;

  multicycle_control_unit #(.ENABLE_BNE(1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .funct(funct), .zero(zero), .memReady(memReady),
    .iorD(iorD), .irWrite(irWrite), .memWrite(memWrite), .regWrite(regWrite),
    .regDst(regDst), .memToReg(memToReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .pcSrc(pcSrc), .pcEn(pcEn), .aluControl(aluControl), .state(state),
    .instrDone(instrDone), .illegalOp(illegalOp)
  );

  multicycle_control_unit #(.ENABLE_BNE(0)) dut_nb (
    .clk(clk), .reset(reset), .Op(Op), .funct(funct), .zero(zero), .memReady(memReady),
    .iorD(nb_iorD), .irWrite(nb_irWrite), .memWrite(nb_memWrite), .regWrite(nb_regWrite),
    .regDst(nb_regDst), .memToReg(nb_memToReg), .aluSrcA(nb_aluSrcA), .aluSrcB(nb_aluSrcB),
    .pcSrc(nb_pcSrc), .pcEn(nb_pcEn), .aluControl(nb_aluControl), .state(nb_state),
    .instrDone(nb_instrDone), .illegalOp(nb_illegalOp)
  );

  typedef struct packed {
    logic       mr;
    logic [3:0] st;
    logic       iord, irw, memw, regw, regdst, m2r, srca;
    logic [1:0] srcb, pcsrc;
    logic       pcen;
    logic [2:0] aluc;
    logic       done, ill;
  } cyc_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         lat;
    logic       ill;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  cyc_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cyc_t sample(input logic mr);
    cyc_t c;
    c = '{mr: mr, st: state, iord: iorD, irw: irWrite, memw: memWrite, regw: regWrite,
          regdst: regDst, m2r: memToReg, srca: aluSrcA, srcb: aluSrcB, pcsrc: pcSrc,
          pcen: pcEn, aluc: aluControl, done: instrDone, ill: illegalOp};
    return c;
  endfunction

  task automatic check_cyc(input string name, input int idx, input cyc_t exp);
    cyc_t act;
    act = sample(exp.mr);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  function automatic logic [2:0] alu_ref(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // memReady is random outside wait states; the DUT must ignore it there
  function automatic cyc_t base(input logic [3:0] st);
    cyc_t c;
    c = '0;
    c.st = st;
    c.aluc = 3'b010;
    c.mr = 1'($urandom);
    return c;
  endfunction

  // Expected cycle-by-cycle trace of one instruction; fw/mw = wait cycles before memReady
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw);
    cyc_t c;
    q.delete();
    for (int i = 0; i <= fw; i++) begin
      c = base(4'd0);
      c.srcb = 2'b01;
      c.mr = (i == fw);
      c.irw = c.mr;
      c.pcen = c.mr;
      q.push_back(c);
    end
    c = base(4'd1);
    c.srcb = 2'b11;
    if (!(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                     6'b001000, 6'b000010})) begin
      c.ill = 1'b1;
      c.done = 1'b1;
      q.push_back(c);
      return;
    end
    q.push_back(c);
    case (op)
      6'b100011, 6'b101011: begin
        c = base(4'd2); c.srca = 1'b1; c.srcb = 2'b10; q.push_back(c);
        for (int i = 0; i <= mw; i++) begin
          c = base(op == 6'b100011 ? 4'd3 : 4'd5);
          c.iord = 1'b1;
          c.mr = (i == mw);
          if (op == 6'b101011) begin
            c.memw = 1'b1;
            c.done = c.mr;
          end
          q.push_back(c);
        end
        if (op == 6'b100011) begin
          c = base(4'd4); c.regw = 1'b1; c.m2r = 1'b1; c.done = 1'b1; q.push_back(c);
        end
      end
      6'b000000: begin
        c = base(4'd6); c.srca = 1'b1; c.aluc = alu_ref(fn); q.push_back(c);
        c = base(4'd7); c.regw = 1'b1; c.regdst = 1'b1; c.done = 1'b1; q.push_back(c);
      end
      6'b001000: begin
        c = base(4'd9); c.srca = 1'b1; c.srcb = 2'b10; q.push_back(c);
        c = base(4'd10); c.regw = 1'b1; c.done = 1'b1; q.push_back(c);
      end
      6'b000100, 6'b000101: begin
        c = base(4'd8); c.srca = 1'b1; c.aluc = 3'b110; c.pcsrc = 2'b01; c.done = 1'b1;
        c.pcen = (op == 6'b000101) ? !z : z;
        q.push_back(c);
      end
      default: begin
        c = base(4'd11); c.pcsrc = 2'b10; c.pcen = 1'b1; c.done = 1'b1; q.push_back(c);
      end
    endcase
  endtask

  task automatic run_model(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fw, input int mw);
    build(op, fn, z, fw, mw);
    foreach (q[i]) begin
      @(negedge clk);
      if (i == 0) begin
        Op = op; funct = fn; zero = z;
      end
      memReady = q[i].mr;
      #1;
      check_cyc(name, i, q[i]);
    end
  endtask

  task automatic run_lat(input vec_t v);
    int n = 0;
    bit done = 0;
    bit saw_ill = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        Op = v.op; funct = v.fn; zero = v.z;
      end
      memReady = 1'b1;
      #1;
      n++;
      if (illegalOp) saw_ill = 1;
      if (instrDone) done = 1;
    end
    check($sformatf("latency op=%b", v.op), n, v.lat);
    check($sformatf("illegal op=%b", v.op), 32'(saw_ill), 32'(v.ill));
  endtask

  vec_t       tbl[10];
  logic [5:0] ops[8];
  logic [5:0] fns[5];

  initial begin
    tbl[0] = '{6'b100011, 6'b000000, 1'b0, 5, 1'b0};
    tbl[1] = '{6'b101011, 6'b000000, 1'b0, 4, 1'b0};
    tbl[2] = '{6'b000000, 6'b100000, 1'b0, 4, 1'b0};
    tbl[3] = '{6'b000000, 6'b101010, 1'b0, 4, 1'b0};
    tbl[4] = '{6'b001000, 6'b000000, 1'b0, 4, 1'b0};
    tbl[5] = '{6'b000100, 6'b000000, 1'b1, 3, 1'b0};
    tbl[6] = '{6'b000101, 6'b000000, 1'b1, 3, 1'b0};
    tbl[7] = '{6'b000010, 6'b000000, 1'b0, 3, 1'b0};
    tbl[8] = '{6'b111111, 6'b000000, 1'b0, 2, 1'b1};
    tbl[9] = '{6'b000001, 6'b000000, 1'b0, 2, 1'b1};
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000,
            6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b1; memReady = 1'b1; zero = 1'b0; Op = 6'b0; funct = 6'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset state", 32'(state), 32'd0);
    check("reset strobes", {irWrite, memWrite, regWrite, pcEn, instrDone, illegalOp}, 32'd0);
    check("reset aluSrcB", 32'(aluSrcB), 32'b01);
    @(negedge clk);
    reset = 1'b0; memReady = 1'b0;

    foreach (tbl[i]) run_lat(tbl[i]);

    run_model("lw", 6'b100011, 6'b0, 1'b0, 0, 0);
    run_model("sw_wait3", 6'b101011, 6'b0, 1'b0, 0, 3);
    run_model("beq_z1", 6'b000100, 6'b0, 1'b1, 0, 0);
    run_model("beq_z0", 6'b000100, 6'b0, 1'b0, 1, 0);
    run_model("bne_z1", 6'b000101, 6'b0, 1'b1, 0, 0);
    run_model("bne_z0", 6'b000101, 6'b0, 1'b0, 0, 0);
    run_model("slt", 6'b000000, 6'b101010, 1'b0, 0, 0);
    run_model("illegal", 6'b111111, 6'b0, 1'b0, 2, 0);

    for (int k = 0; k < 40; k++) begin
      int oi;
      logic [5:0] op, fn;
      oi = $urandom_range(0, 8);
      op = (oi == 8) ? 6'($urandom) : ops[oi];
      fn = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_model($sformatf("rand%0d", k), op, fn, 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset while in EXECUTE aborts the R-type before its write-back
    @(negedge clk); Op = 6'b000000; funct = 6'b101010; memReady = 1'b1; #1;
    check("abort fetch", 32'(state), 32'd0);
    @(negedge clk); #1;
    check("abort decode", 32'(state), 32'd1);
    @(negedge clk); reset = 1'b1; #1;
    check("abort in exec state", 32'(state), 32'd6);
    check("abort exec strobes", {irWrite, memWrite, regWrite, pcEn}, 32'd0);
    check("abort exec aluctl", 32'(aluControl), 32'b010);
    @(negedge clk); #1;
    check("abort reset2 state", 32'(state), 32'd0);
    check("abort reset2 strobes", {irWrite, memWrite, regWrite, pcEn, instrDone}, 32'd0);
    @(negedge clk); reset = 1'b0; memReady = 1'b0; #1;
    check("abort released state", 32'(state), 32'd0);
    check("abort released irWrite", 32'(irWrite), 32'd0);
    run_model("after_abort", 6'b001000, 6'b0, 1'b0, 0, 0);

    // ENABLE_BNE=0 instance must flag bne as illegal
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; Op = 6'b000101; zero = 1'b1; memReady = 1'b1; #1;
    check("nb fetch state", 32'(nb_state), 32'd0);
    @(negedge clk); #1;
    check("nb decode illegal", {nb_illegalOp, nb_instrDone}, 32'b11);
    check("nb decode writes", {nb_irWrite, nb_memWrite, nb_regWrite, nb_pcEn}, 32'd0);
    check("bne legal in dut", 32'(illegalOp), 32'd0);
    @(negedge clk); #1;
    check("nb back to fetch", 32'(nb_state), 32'd0);
    check("dut in branch", 32'(state), 32'd8);
    check("dut bne z1 pcEn", 32'(pcEn), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
